serial_bit_streamer: RTL and testbench

SERIAL_BIT_STREAMER -- requirements
Module: serial_bit_streamer

---
 rtl/serial_bit_streamer_pkg.sv | 10 +
 rtl/serial_bit_streamer.sv | 105 ++++++++++
 tb/tb_serial_bit_streamer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_streamer_pkg.sv
// Shared FSM state encoding for the serializer and the downstream
// bit-serial sequence-detector blocks.
package serial_bit_streamer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/serial_bit_streamer.sv
// Parallel-to-serial word streamer: one shift register plus one holding
// register, gapless back-to-back words, registered in_ready.
module serial_bit_streamer
   import serial_bit_streamer_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_start,
   output logic             busy
);

   localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ready_q;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] shifted;
   logic             head_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         // ready tracks the holding register's next occupancy; held low in reset
         ready_q     <= ~hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      accept   = in_valid && ready_q;
      last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
      shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
      head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = in_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               // held word has priority; in_ready is low whenever it is present
               cnt_d = '0;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  shift_d = in_data;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               shift_d = shifted;
               cnt_d   = cnt_q + CW'(1);
               if (accept) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = ready_q;
   assign bit_valid  = (state_q == SHIFT);
   assign bit_out    = bit_valid ? head_bit : IDLE_BIT;
   assign word_start = bit_valid && (cnt_q == '0);
   assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed bench for serial_bit_streamer: default MSB-first instance plus an
// LSB-first, idle-high instance feeding a 10101 detector model.
module tb_serial_bit_streamer;

   logic       clk;
   logic       rst;
   logic [7:0] d_in_data;
   logic       d_in_valid, d_in_ready, d_bit_out, d_bit_valid, d_word_start, d_busy;
   logic [7:0] a_in_data;
   logic       a_in_valid, a_in_ready, a_bit_out, a_bit_valid, a_word_start, a_busy;

   int checks = 0;
   int errors = 0;

   serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .bit_out(d_bit_out), .bit_valid(d_bit_valid),
      .word_start(d_word_start), .busy(d_busy)
   );

   serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_alt (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
      .word_start(a_word_start), .busy(a_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      checks++;
      if (d_in_ready !== 1'b0 || d_bit_valid !== 1'b0 || d_word_start !== 1'b0 ||
          d_busy !== 1'b0 || d_bit_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b bv=%b ws=%b busy=%b bo=%b, required 0 0 0 0 0",
                  d_in_ready, d_bit_valid, d_word_start, d_busy, d_bit_out);
      end
      checks++;
      if (a_bit_out !== 1'b1 || a_bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_high: bo=%b bv=%b, required 1 0", a_bit_out, a_bit_valid);
      end
      tick;
      rst = 1'b0;
      checks++;
      if (d_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b, required 0", d_in_ready);
      end
      tick;
      checks++;
      if (d_in_ready !== 1'b1 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release: got %b/%b, required 1/1", d_in_ready, a_in_ready);
      end
   endtask

   task automatic test_single;
      logic [7:0] w;
      w = 8'hA8;
      d_in_data  = w;
      d_in_valid = 1'b1;
      tick;
      d_in_valid = 1'b0;
      d_in_data  = '0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (d_bit_valid !== 1'b1 || d_bit_out !== w[7-i]) begin
            errors++;
            $display("FAIL single_bit%0d: bv=%b bo=%b, required bv=1 bo=%b", i, d_bit_valid, d_bit_out, w[7-i]);
         end
         checks++;
         if (d_word_start !== (i == 0)) begin
            errors++;
            $display("FAIL single_ws%0d: got %b, required %b", i, d_word_start, (i == 0));
         end
         tick;
      end
      checks++;
      if (d_bit_valid !== 1'b0 || d_bit_out !== 1'b0 || d_word_start !== 1'b0 || d_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_after: bv=%b bo=%b ws=%b busy=%b, required 0 0 0 0",
                  d_bit_valid, d_bit_out, d_word_start, d_busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] seq;
      seq = 16'hA855;
      d_in_data  = 8'hA8;
      d_in_valid = 1'b1;
      tick;
      for (int c = 0; c < 16; c++) begin
         if (c == 0) d_in_data = 8'h55;
         if (c == 1) d_in_valid = 1'b0;
         checks++;
         if (d_bit_valid !== 1'b1 || d_bit_out !== seq[15-c]) begin
            errors++;
            $display("FAIL b2b_bit%0d: bv=%b bo=%b, required bv=1 bo=%b", c, d_bit_valid, d_bit_out, seq[15-c]);
         end
         checks++;
         if (d_word_start !== (c == 0 || c == 8)) begin
            errors++;
            $display("FAIL b2b_ws%0d: got %b, required %b", c, d_word_start, (c == 0 || c == 8));
         end
         checks++;
         if (d_in_ready !== (c == 0 || c >= 8) || d_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d: rdy=%b busy=%b, required rdy=%b busy=1",
                     c, d_in_ready, d_busy, (c == 0 || c >= 8));
         end
         tick;
      end
      checks++;
      if (d_bit_valid !== 1'b0 || d_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_after: bv=%b busy=%b, required 0 0", d_bit_valid, d_busy);
      end
   endtask

   task automatic test_last_edge;
      logic [15:0] seq;
      seq = 16'hC33C;
      d_in_data  = 8'hC3;
      d_in_valid = 1'b1;
      tick;
      d_in_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c == 7) begin
            d_in_data  = 8'h3C;
            d_in_valid = 1'b1;
         end
         if (c == 8) d_in_valid = 1'b0;
         checks++;
         if (d_bit_valid !== 1'b1 || d_bit_out !== seq[15-c] || d_word_start !== (c == 0 || c == 8)) begin
            errors++;
            $display("FAIL last_edge%0d: bv=%b bo=%b ws=%b, required 1 %b %b",
                     c, d_bit_valid, d_bit_out, d_word_start, seq[15-c], (c == 0 || c == 8));
         end
         checks++;
         if (d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_edge_ready%0d: got %b, required 1", c, d_in_ready);
         end
         tick;
      end
      checks++;
      if (d_bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL last_edge_after: bv=%b, required 0", d_bit_valid);
      end
   endtask

   task automatic test_lsb_detect;
      logic [7:0] exp_bits;
      logic [4:0] hist;
      int n, pulses, pulse_at;
      exp_bits = 8'b0001_0101;
      hist = '0;
      n = 0;
      pulses = 0;
      pulse_at = -1;
      a_in_data  = 8'h15;
      a_in_valid = 1'b1;
      tick;
      a_in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (a_bit_valid !== 1'b1 || a_bit_out !== exp_bits[i] || a_word_start !== (i == 0)) begin
            errors++;
            $display("FAIL lsb_bit%0d: bv=%b bo=%b ws=%b, required 1 %b %b",
                     i, a_bit_valid, a_bit_out, a_word_start, exp_bits[i], (i == 0));
         end
         if (a_bit_valid === 1'b1) begin
            hist = {hist[3:0], a_bit_out};
            n++;
            if (n >= 5 && hist == 5'b10101) begin
               pulses++;
               pulse_at = i;
               n = 0;
            end
         end
         tick;
      end
      checks++;
      if (pulses != 1 || pulse_at != 4) begin
         errors++;
         $display("FAIL lsb_detect: pulses=%0d at bit index %0d, required 1 at 4", pulses, pulse_at);
      end
      checks++;
      if (a_bit_valid !== 1'b0 || a_bit_out !== 1'b1 || a_word_start !== 1'b0) begin
         errors++;
         $display("FAIL lsb_after: bv=%b bo=%b ws=%b, required 0 1 0", a_bit_valid, a_bit_out, a_word_start);
      end
   endtask

   task automatic test_idle_high;
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (a_bit_out !== 1'b1 || a_bit_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            bad++;
            if (bad <= 3)
               $display("FAIL idle_high%0d: bo=%b bv=%b busy=%b, required 1 0 0", i, a_bit_out, a_bit_valid, a_busy);
         end
         tick;
      end
   endtask

   task automatic test_reset_mid;
      d_in_data  = 8'hFF;
      d_in_valid = 1'b1;
      tick;
      d_in_valid = 1'b0;
      tick;
      tick;
      tick;
      checks++;
      if (d_bit_valid !== 1'b1 || d_bit_out !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: bv=%b bo=%b, required 1 1", d_bit_valid, d_bit_out);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (d_bit_valid !== 1'b0 || d_bit_out !== 1'b0 || d_word_start !== 1'b0 ||
          d_busy !== 1'b0 || d_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: bv=%b bo=%b ws=%b busy=%b rdy=%b, required 0 0 0 0 0",
                  d_bit_valid, d_bit_out, d_word_start, d_busy, d_in_ready);
      end
      tick;
      rst = 1'b0;
      checks++;
      if (d_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready_early: got %b, required 0", d_in_ready);
      end
      tick;
      checks++;
      if (d_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ready: got %b, required 1", d_in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (d_bit_valid !== 1'b0 || d_bit_out !== 1'b0 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_resume%0d: bv=%b bo=%b busy=%b, required 0 0 0",
                     i, d_bit_valid, d_bit_out, d_busy);
         end
         tick;
      end
   endtask

   initial begin
      rst        = 1'b1;
      d_in_data  = '0;
      d_in_valid = 1'b0;
      a_in_data  = '0;
      a_in_valid = 1'b0;
      #2;
      test_reset;
      test_single;
      test_back_to_back;
      test_last_edge;
      test_idle_high;
      test_lsb_detect;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
